// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing control FSM for one distributed-processor core.
// Decodes the instruction class in opcode[7:4] and drives ALU selects, write
// enables, instruction-pointer control and fproc/sync handshakes. Adds a sync
// barrier wait, a terminal DONE state and a wait timeout with a sticky error.
module proc_ctrl_fsm #(
  parameter int unsigned OPCODE_W      = 8,
  parameter int unsigned TIMEOUT_W     = 16,
  parameter int unsigned FPROC_TIMEOUT = 1024,
  parameter int unsigned SYNC_TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                fproc_ready,
  input  logic                sync_enable,
  input  logic                sync_in,
  input  logic                cstrobe_in,
  output logic [2:0]          alu_opcode,
  output logic                alu_in0_sel,
  output logic [1:0]          alu_in1_sel,
  output logic                c_strobe_enable,
  output logic                reg_write_en,
  output logic                instr_ptr_en,
  output logic [1:0]          instr_ptr_load_en,
  output logic                qclk_load_en,
  output logic                write_pulse_en,
  output logic                fproc_out_ready,
  output logic                sync_out_ready,
  output logic                done,
  output logic                timeout_err
);

  localparam logic [3:0] C_PULSE_WRITE      = 4'd1;
  localparam logic [3:0] C_PULSE_WRITE_TRIG = 4'd2;
  localparam logic [3:0] C_REG_ALU          = 4'd3;
  localparam logic [3:0] C_JUMP_I           = 4'd4;
  localparam logic [3:0] C_JUMP_COND        = 4'd5;
  localparam logic [3:0] C_INC_QCLK         = 4'd6;
  localparam logic [3:0] C_ALU_FPROC        = 4'd7;
  localparam logic [3:0] C_JUMP_FPROC       = 4'd8;
  localparam logic [3:0] C_SYNC             = 4'd9;
  localparam logic [3:0] C_DONE             = 4'd10;

  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_QCLK  = 2'd1;
  localparam logic [1:0] SEL_FPROC = 2'd2;

  localparam logic [1:0] LD_INC  = 2'd0;
  localparam logic [1:0] LD_IMM  = 2'd1;
  localparam logic [1:0] LD_ALU  = 2'd2;

  localparam bit                   FPROC_TO_EN = (FPROC_TIMEOUT != 0);
  localparam bit                   SYNC_TO_EN  = (SYNC_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] FPROC_LAST  = TIMEOUT_W'(FPROC_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] SYNC_LAST   = TIMEOUT_W'(SYNC_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [3:0] {
    S_INIT, S_ALU_PROC, S_INC_QCLK, S_JUMP_COND,
    S_AFP_WAIT, S_JFP_WAIT, S_SYNC_WAIT, S_DONE, S_ERR
  } state_t;

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_src_fproc;

  logic [3:0] w_class;
  logic       w_fproc_expire;
  logic       w_sync_expire;
  logic [1:0] w_hold_sel;
  logic       w_unused_opcode;

  assign w_class         = opcode[7:4];
  assign w_unused_opcode = ^opcode;
  assign w_fproc_expire  = FPROC_TO_EN && (r_wait_cnt == FPROC_LAST);
  assign w_sync_expire   = SYNC_TO_EN && (r_wait_cnt == SYNC_LAST);
  assign w_hold_sel      = r_src_fproc ? SEL_FPROC : SEL_REG;

  // State, saturating wait counter and held ALU operand source.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_wait_cnt  <= '0;
      r_src_fproc <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_wait_cnt <= '0;
          case (w_class)
            C_REG_ALU:    begin r_state <= S_ALU_PROC;  r_src_fproc <= 1'b0; end
            C_JUMP_COND:  begin r_state <= S_JUMP_COND; r_src_fproc <= 1'b0; end
            C_INC_QCLK:   r_state <= S_INC_QCLK;
            C_ALU_FPROC:  r_state <= S_AFP_WAIT;
            C_JUMP_FPROC: r_state <= S_JFP_WAIT;
            C_SYNC:       if (sync_enable) r_state <= S_SYNC_WAIT;
            C_DONE:       r_state <= S_DONE;
            default:      r_state <= S_INIT;
          endcase
        end
        S_ALU_PROC, S_INC_QCLK, S_JUMP_COND: r_state <= S_INIT;
        S_AFP_WAIT, S_JFP_WAIT: begin
          if (fproc_ready) begin
            r_state     <= (r_state == S_AFP_WAIT) ? S_ALU_PROC : S_JUMP_COND;
            r_src_fproc <= 1'b1;
          end else if (w_fproc_expire) begin
            r_state <= S_ERR;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end
        end
        S_SYNC_WAIT: begin
          if (sync_in) begin
            r_state <= S_INIT;
          end else if (w_sync_expire) begin
            r_state <= S_ERR;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Control outputs decoded from state, opcode and handshake inputs.
  always_comb begin
    alu_opcode        = opcode[2:0];
    alu_in0_sel       = opcode[3];
    alu_in1_sel       = SEL_REG;
    c_strobe_enable   = 1'b0;
    reg_write_en      = 1'b0;
    instr_ptr_en      = 1'b0;
    instr_ptr_load_en = LD_INC;
    qclk_load_en      = 1'b0;
    write_pulse_en    = 1'b0;
    fproc_out_ready   = 1'b0;
    sync_out_ready    = 1'b0;
    done              = 1'b0;
    timeout_err       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_INIT: begin
          case (w_class)
            C_PULSE_WRITE: begin
              write_pulse_en = 1'b1;
              instr_ptr_en   = 1'b1;
            end
            C_PULSE_WRITE_TRIG: begin
              write_pulse_en  = 1'b1;
              c_strobe_enable = 1'b1;
              instr_ptr_en    = cstrobe_in;
            end
            C_JUMP_I: begin
              instr_ptr_en      = 1'b1;
              instr_ptr_load_en = LD_IMM;
            end
            C_INC_QCLK:                fproc_out_ready = 1'b0;
            C_ALU_FPROC, C_JUMP_FPROC: fproc_out_ready = 1'b1;
            C_SYNC: begin
              sync_out_ready = sync_enable;
              instr_ptr_en   = !sync_enable;
            end
            default: ;
          endcase
          if (w_class == C_INC_QCLK) alu_in1_sel = SEL_QCLK;
        end
        S_ALU_PROC: begin
          alu_in1_sel  = w_hold_sel;
          reg_write_en = 1'b1;
          instr_ptr_en = 1'b1;
        end
        S_INC_QCLK: begin
          alu_in1_sel  = SEL_QCLK;
          qclk_load_en = 1'b1;
          instr_ptr_en = 1'b1;
        end
        S_JUMP_COND: begin
          alu_in1_sel       = w_hold_sel;
          instr_ptr_en      = 1'b1;
          instr_ptr_load_en = LD_ALU;
        end
        S_AFP_WAIT, S_JFP_WAIT: alu_in1_sel = SEL_FPROC;
        S_SYNC_WAIT:            instr_ptr_en = sync_in;
        S_DONE:                 done = 1'b1;
        S_ERR: begin
          done        = 1'b1;
          timeout_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized and directed bench for proc_ctrl_fsm against a behavioural model
// that tracks which instruction phase the core is in.
module tb_proc_ctrl_fsm;

  localparam int unsigned OPCODE_W = 10;
  localparam int unsigned TO_W     = 8;
  localparam int unsigned FP_TO    = 4;
  localparam int unsigned SY_TO    = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [OPCODE_W-1:0] opcode;
  logic                fproc_ready, sync_enable, sync_in, cstrobe_in;
  logic [2:0]          alu_opcode;
  logic                alu_in0_sel;
  logic [1:0]          alu_in1_sel;
  logic                c_strobe_enable, reg_write_en, instr_ptr_en;
  logic [1:0]          instr_ptr_load_en;
  logic                qclk_load_en, write_pulse_en, fproc_out_ready;
  logic                sync_out_ready, done, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proc_ctrl_fsm #(
    .OPCODE_W(OPCODE_W), .TIMEOUT_W(TO_W),
    .FPROC_TIMEOUT(FP_TO), .SYNC_TIMEOUT(SY_TO)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .fproc_ready(fproc_ready), .sync_enable(sync_enable),
    .sync_in(sync_in), .cstrobe_in(cstrobe_in),
    .alu_opcode(alu_opcode), .alu_in0_sel(alu_in0_sel),
    .alu_in1_sel(alu_in1_sel), .c_strobe_enable(c_strobe_enable),
    .reg_write_en(reg_write_en), .instr_ptr_en(instr_ptr_en),
    .instr_ptr_load_en(instr_ptr_load_en), .qclk_load_en(qclk_load_en),
    .write_pulse_en(write_pulse_en), .fproc_out_ready(fproc_out_ready),
    .sync_out_ready(sync_out_ready), .done(done), .timeout_err(timeout_err)
  );

  // Model phases: what the core is doing this cycle.
  localparam int M_FETCH = 0, M_EXEC_ALU = 1, M_EXEC_QCLK = 2, M_EXEC_JMP = 3;
  localparam int M_WAIT_ALU = 4, M_WAIT_JMP = 5, M_WAIT_SYNC = 6;
  localparam int M_HALT = 7, M_FAULT = 8;

  int m_phase = M_FETCH;
  int m_waited = 0;
  bit m_from_fproc = 1'b0;

  // Field order: aluop(3) in0(1) in1(2) cstb wr ipen ipld(2) qclk pulse freq sreq done terr
  function automatic logic [16:0] model_out(input logic [OPCODE_W-1:0] op,
      input logic fr, input logic se, input logic si, input logic cs,
      input logic rst);
    logic [1:0] sel = 2'd0, ld = 2'd0;
    logic cstb = 0, wr = 0, ip = 0, qc = 0, pw = 0, frq = 0, srq = 0;
    logic dn = 0, te = 0;
    int cls = int'(op[7:4]);
    if (!rst) begin
      if (m_phase == M_FETCH) begin
        if (cls == 1) begin pw = 1; ip = 1; end
        if (cls == 2) begin pw = 1; cstb = 1; ip = cs; end
        if (cls == 4) begin ip = 1; ld = 2'd1; end
        if (cls == 6) sel = 2'd1;
        if (cls == 7 || cls == 8) frq = 1;
        if (cls == 9) begin srq = se; ip = !se; end
      end else if (m_phase == M_EXEC_ALU) begin
        wr = 1; ip = 1; sel = m_from_fproc ? 2'd2 : 2'd0;
      end else if (m_phase == M_EXEC_QCLK) begin
        sel = 2'd1; qc = 1; ip = 1;
      end else if (m_phase == M_EXEC_JMP) begin
        ip = 1; ld = 2'd2; sel = m_from_fproc ? 2'd2 : 2'd0;
      end else if (m_phase == M_WAIT_ALU || m_phase == M_WAIT_JMP) begin
        sel = 2'd2;
      end else if (m_phase == M_WAIT_SYNC) begin
        ip = si;
      end else if (m_phase == M_HALT) begin
        dn = 1;
      end else begin
        dn = 1; te = 1;
      end
    end
    return {op[2:0], op[3], sel, cstb, wr, ip, ld, qc, pw, frq, srq, dn, te};
  endfunction

  task automatic model_advance(input logic [OPCODE_W-1:0] op, input logic fr,
      input logic se, input logic si, input logic rst);
    int cls = int'(op[7:4]);
    int limit;
    if (rst) begin
      m_phase = M_FETCH; m_waited = 0; m_from_fproc = 0;
      return;
    end
    if (m_phase == M_FETCH) begin
      m_waited = 0;
      if (cls == 3) begin m_phase = M_EXEC_ALU; m_from_fproc = 0; end
      else if (cls == 5) begin m_phase = M_EXEC_JMP; m_from_fproc = 0; end
      else if (cls == 6) m_phase = M_EXEC_QCLK;
      else if (cls == 7) m_phase = M_WAIT_ALU;
      else if (cls == 8) m_phase = M_WAIT_JMP;
      else if (cls == 9 && se) m_phase = M_WAIT_SYNC;
      else if (cls == 10) m_phase = M_HALT;
    end else if (m_phase >= M_EXEC_ALU && m_phase <= M_EXEC_JMP) begin
      m_phase = M_FETCH;
    end else if (m_phase >= M_WAIT_ALU && m_phase <= M_WAIT_SYNC) begin
      limit = (m_phase == M_WAIT_SYNC) ? int'(SY_TO) : int'(FP_TO);
      if (m_phase == M_WAIT_SYNC && si) begin
        m_phase = M_FETCH;
      end else if (m_phase != M_WAIT_SYNC && fr) begin
        m_phase = (m_phase == M_WAIT_ALU) ? M_EXEC_ALU : M_EXEC_JMP;
        m_from_fproc = 1;
      end else if (limit != 0 && m_waited == limit - 1) begin
        m_phase = M_FAULT;
      end else if (m_waited < (1 << TO_W) - 1) begin
        m_waited = m_waited + 1;
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [16:0] got,
      input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare mid-cycle, then advance the model.
  task automatic step(input string tag, input logic [OPCODE_W-1:0] op,
      input logic fr, input logic se, input logic si, input logic cs,
      input logic rst);
    logic [16:0] exp;
    opcode = op; fproc_ready = fr; sync_enable = se; sync_in = si;
    cstrobe_in = cs; reset = rst;
    @(negedge clk);
    exp = model_out(op, fr, se, si, cs, rst);
    check_eq(tag, {alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable,
                   reg_write_en, instr_ptr_en, instr_ptr_load_en,
                   qclk_load_en, write_pulse_en, fproc_out_ready,
                   sync_out_ready, done, timeout_err}, exp);
    @(posedge clk);
    model_advance(op, fr, se, si, rst);
    #1;
  endtask

  function automatic logic [OPCODE_W-1:0] rand_op();
    logic [OPCODE_W-1:0] op = OPCODE_W'($urandom);
    if ($urandom_range(0, 29) != 0 && op[7:4] == 4'd10) op[7:4] = 4'd3;
    return op;
  endfunction

  initial begin
    reset = 1'b1; opcode = '0; fproc_ready = 0; sync_enable = 0;
    sync_in = 0; cstrobe_in = 0;
    @(posedge clk); #1;
    step("reset0", 10'h3FF, 1, 1, 1, 1, 1);
    step("reset1", 10'h07B, 0, 0, 0, 0, 1);

    step("regalu_c0", 10'h032, 0, 0, 0, 0, 0);
    step("regalu_c1", 10'h032, 0, 0, 0, 0, 0);
    step("regalu_back", 10'h000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) step("ptrig_wait", 10'h020, 0, 0, 0, 0, 0);
    step("ptrig_fire", 10'h020, 0, 0, 0, 1, 0);

    step("jfp_issue", 10'h080, 0, 0, 0, 0, 0);
    step("jfp_wait1", 10'h080, 0, 0, 0, 0, 0);
    step("jfp_wait2", 10'h080, 0, 0, 0, 0, 0);
    step("jfp_ready", 10'h080, 1, 0, 0, 0, 0);
    step("jfp_jump", 10'h080, 0, 0, 0, 0, 0);

    step("afp_issue", 10'h370, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("afp_towait", 10'h370, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("err_hold", rand_op(), 1, 1, 1, 1, 0);
    step("err_reset", 10'h070, 0, 0, 0, 0, 1);
    step("err_cleared", 10'h000, 0, 0, 0, 0, 0);

    step("sync_off", 10'h090, 0, 0, 0, 0, 0);
    step("sync_issue", 10'h090, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("sync_wait", 10'h090, 0, 1, 0, 0, 0);
    step("sync_release", 10'h090, 0, 1, 1, 0, 0);
    step("sync_after", 10'h000, 0, 1, 0, 0, 0);

    step("sync_to_issue", 10'h090, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("sync_to_wait", 10'h090, 0, 1, 0, 0, 0);
    step("sync_to_reset", 10'h000, 0, 0, 0, 0, 1);

    step("done_issue", 10'h0A0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++)
      step("done_hold", OPCODE_W'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 0);
    step("done_reset", 10'h000, 0, 0, 0, 0, 1);
    step("midwait_issue", 10'h070, 0, 0, 0, 0, 0);
    step("midwait_wait", 10'h070, 0, 0, 0, 0, 0);
    step("midwait_reset", 10'h070, 1, 0, 0, 0, 1);
    step("midwait_after", 10'h000, 1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++)
      step("random", rand_op(), ($urandom_range(0, 9) < 3),
           1'($urandom), ($urandom_range(0, 9) < 2), 1'($urandom),
           ($urandom_range(0, 39) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
